// File: rtl/md5_pkg.sv
// md5_pkg: shared types and constants for the md5 message padder.
package md5_pkg;
  typedef logic [511:0] md5_block_t;
  typedef logic [127:0] md5_digest_t;
  typedef enum logic [1:0] {COLLECT, PAD, ISSUE, WAIT} pad_state_e;
  localparam int MD5_LEN_BYTE0 = 56;
  localparam logic [7:0] MD5_PAD_MARKER = 8'h80;
endpackage

// File: rtl/md5_pad_fmt.sv
// md5_pad_fmt: maps stored message bytes and length to a padded single md5 block.
module md5_pad_fmt
  import md5_pkg::*;
(
  input  logic [8*MD5_LEN_BYTE0-1:0] data,
  input  logic [5:0]                 len,
  output md5_block_t                 blk
);
  logic [63:0] bit_len;
  assign bit_len = {55'd0, len, 3'd0};
  for (genvar i = 0; i < 64; i++) begin : g_byte
    if (i >= MD5_LEN_BYTE0) begin : g_len
      assign blk[511-8*i -: 8] = bit_len[8*(i-MD5_LEN_BYTE0) +: 8];
    end else begin : g_msg
      assign blk[511-8*i -: 8] = (6'(i) < len) ? data[8*i +: 8] :
                                 (6'(i) == len) ? MD5_PAD_MARKER : 8'h00;
    end
  end
endmodule

// File: rtl/md5_msg_padder.sv
// md5_msg_padder: byte stream to padded md5 block, issue to core, return digest.
// Define MD5_PAD_ERR_CNT_EN to add the saturating err_cnt output.
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int MAX_MSG_BYTES  = 55,
  parameter int DIGEST_TIMEOUT = 127,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        in_ready,
  output md5_block_t  msg_padded,
  output logic        msg_in_valid,
  input  logic        md5_ready,
  input  logic        md5_out_valid,
  input  md5_digest_t md5_digest,
  output md5_digest_t digest,
  output logic        digest_valid,
  output logic        len_err,
  output logic        timeout_err,
  output logic        busy
`ifdef MD5_PAD_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  localparam int TMR_W = $clog2(DIGEST_TIMEOUT + 1);
  pad_state_e state, state_nx;
  logic [5:0] cnt;
  logic ovf, take, last, store, bad, capture, expire;
  logic [8*MD5_LEN_BYTE0-1:0] data;
  logic [TMR_W-1:0] tmr;
  md5_block_t fmt_blk;
  assign in_ready     = ~rst & (state == COLLECT);
  assign msg_in_valid = ~rst & (state == ISSUE) & md5_ready;
  assign busy         = state != COLLECT;
  assign take    = in_valid & in_ready;
  assign last    = take & in_last;
  assign store   = take & ~(in_last & in_empty);
  // bad covers both an earlier overflow and the byte that would overflow now
  assign bad     = ovf | (store & (cnt == 6'(MAX_MSG_BYTES)));
  assign capture = (state == WAIT) & md5_out_valid;
  assign expire  = (state == WAIT) & ~md5_out_valid & (tmr == TMR_W'(DIGEST_TIMEOUT - 1));
  md5_pad_fmt u_fmt (.data(data), .len(cnt), .blk(fmt_blk));
  always_ff @(posedge clk)
    if (rst) state <= COLLECT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      COLLECT: state_nx = (last && !bad) ? PAD : COLLECT;
      PAD:     state_nx = ISSUE;
      ISSUE:   state_nx = md5_ready ? WAIT : ISSUE;
      WAIT:    state_nx = (md5_out_valid || expire) ? COLLECT : WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      ovf          <= 1'b0;
      data         <= '0;
      tmr          <= '0;
      msg_padded   <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      len_err      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      digest_valid <= capture;
      len_err      <= last & bad;
      timeout_err  <= expire;
      tmr          <= (state == WAIT) ? tmr + 1'b1 : '0;
      if (store && !bad) data[{cnt, 3'b000} +: 8] <= in_byte;
      if (take) begin
        ovf <= bad & ~in_last;
        cnt <= (in_last && (bad || in_empty)) ? '0 : (store && !bad) ? cnt + 6'd1 : cnt;
      end
      if (state == PAD) msg_padded <= fmt_blk;
      if (capture || expire) cnt <= '0;
      if (capture) begin
        digest     <= md5_digest;
        msg_padded <= '0;
      end
    end
  end
`ifdef MD5_PAD_ERR_CNT_EN
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else if (((last && bad) || expire) && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
`endif
endmodule
